// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: turns an ALU effective address plus busB into one
// req/ack data-memory transaction and returns aligned, extended load data.
module lsu_mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          misalign_q, misalign_d;
    logic          bus_err_q, bus_err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          in_misaligned;
    logic          store_q;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [3:0]    be_val;
    logic [31:0]   wdata_val;

    assign store_q = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);

    always_comb begin
        in_misaligned = 1'b0;
        case (mem_op)
            OP_LW, OP_SW:         in_misaligned = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: in_misaligned = addr[0];
            default:              in_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        byte_sel = dm_rdata[7:0];
        case (addr_q[1:0])
            2'd0: byte_sel = dm_rdata[7:0];
            2'd1: byte_sel = dm_rdata[15:8];
            2'd2: byte_sel = dm_rdata[23:16];
            2'd3: byte_sel = dm_rdata[31:24];
            default: byte_sel = dm_rdata[7:0];
        endcase
        half_sel = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        load_val = dm_rdata;
        case (op_q)
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0000, half_sel};
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h000000, byte_sel};
            default: load_val = dm_rdata;
        endcase
    end

    always_comb begin
        be_val    = 4'b1111;
        wdata_val = '0;
        case (op_q)
            OP_SW: begin
                be_val    = 4'b1111;
                wdata_val = wdata_q;
            end
            OP_SH: begin
                be_val    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_val = {2{wdata_q[15:0]}};
            end
            OP_SB: begin
                be_val    = 4'b0001 << addr_q[1:0];
                wdata_val = {4{wdata_q[7:0]}};
            end
            default: begin
                be_val    = 4'b1111;
                wdata_val = '0;
            end
        endcase
    end

    // An ack on the same edge as the timeout expiry takes priority.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        bus_err_d  = bus_err_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d       = mem_op;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    misalign_d = in_misaligned;
                    bus_err_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = in_misaligned ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (dm_ack) begin
                    state_d = S_RESP;
                    if (!store_q) begin
                        rdata_d = load_val;
                    end
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    state_d   = S_RESP;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Memory-side outputs are qualified by the request so they read zero when idle.
    assign dm_req   = (state_q == S_ACCESS);
    assign dm_we    = dm_req & store_q;
    assign dm_addr  = dm_req ? {addr_q[31:2], 2'b00} : '0;
    assign dm_be    = dm_req ? be_val : 4'b0000;
    assign dm_wdata = dm_req ? wdata_val : '0;

    assign busy     = (state_q == S_ACCESS) || (state_q == S_RESP);
    assign done     = (state_q == S_RESP);
    assign rdata    = rdata_q;
    assign misalign = misalign_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized self-checking bench for lsu_mem_stage against a transaction-level
// model of sizes, lanes, extension and ack/timeout timing.
module tb_lsu_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mem_op = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, misalign, bus_err;
    logic [31:0] rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_op(mem_op),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .misalign(misalign), .bus_err(bus_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    int checks = 0;
    int errors = 0;

    logic        exp_busy = 0, exp_done = 0, exp_req = 0, exp_we = 0;
    logic        exp_mis = 0, exp_err = 0;
    logic [31:0] exp_addr = '0, exp_wd = '0, exp_rdata = '0;
    logic [3:0]  exp_be = '0;

    logic        seen_req, seen_we, seen_mis, seen_err;
    logic [31:0] seen_addr, seen_wd;
    logic [3:0]  seen_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd5:       return 4;
            3'd1, 3'd2, 3'd6: return 2;
            default:          return 1;
        endcase
    endfunction

    function automatic bit op_store(input logic [2:0] op);
        return op >= 3'd5;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] word);
        int sz;
        int lane;
        logic [31:0] v;
        sz   = op_size(op);
        lane = int'(a[1:0]);
        v    = word >> (8 * lane);
        if (sz == 4) return word;
        if (sz == 2) begin
            v = v & 32'h0000FFFF;
            if (op == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = v & 32'h000000FF;
            if (op == 3'd3 && v[7]) v = v | 32'hFFFFFF00;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] a);
        logic [3:0] be;
        int sz;
        int lane;
        sz   = op_store(op) ? op_size(op) : 4;
        lane = op_store(op) ? int'(a[1:0]) : 0;
        for (int i = 0; i < 4; i++) be[i] = (i >= lane) && (i < lane + sz);
        return be;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = op_size(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    // Every cycle out of reset, the DUT must match the model's view of the transaction.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("dm_req", dm_req, exp_req);
            check("rdata", rdata, exp_rdata);
            if (exp_req) begin
                check("dm_we", dm_we, exp_we);
                check("dm_addr", dm_addr, exp_addr);
                check("dm_be", dm_be, exp_be);
                if (exp_we) check("dm_wdata", dm_wdata, exp_wd);
            end
            if (exp_done) begin
                check("misalign", misalign, exp_mis);
                check("bus_err", bus_err, exp_err);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that leaves RESP.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input int d, input logic [31:0] word, input bit noisy);
        int n;
        bit acked;
        bit mis;
        mis    = (int'(a[1:0]) % op_size(op)) != 0;
        start  = 1'b1;
        mem_op = op;
        addr   = a;
        wdata  = wd;
        dm_ack = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        dm_rdata = $urandom;
        @(posedge clk); #1;
        start    = 1'b0;
        seen_req = dm_req;
        exp_busy = 1'b1;
        exp_mis  = mis;
        exp_err  = 1'b0;
        if (mis) begin
            exp_req  = 1'b0;
            exp_done = 1'b1;
        end else begin
            exp_req   = 1'b1;
            exp_we    = op_store(op);
            exp_addr  = {a[31:2], 2'b00};
            exp_be    = model_be(op, a);
            exp_wd    = model_wd(op, wd);
            seen_we   = dm_we;
            seen_addr = dm_addr;
            seen_be   = dm_be;
            seen_wd   = dm_wdata;
            n = 0;
            acked = 1'b0;
            while (!acked && n < TO) begin
                dm_ack   = (n == d);
                dm_rdata = (n == d) ? word : $urandom;
                if (noisy) begin
                    start  = 1'($urandom_range(0, 1));
                    mem_op = 3'($urandom);
                    addr   = $urandom;
                    wdata  = $urandom;
                end
                @(posedge clk); #1;
                acked = dm_ack;
                n++;
            end
            start    = 1'b0;
            dm_ack   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_req  = 1'b0;
            exp_done = 1'b1;
            exp_err  = !acked;
            if (acked && !op_store(op)) exp_rdata = model_load(op, a, word);
        end
        seen_mis = misalign;
        seen_err = bus_err;
        @(posedge clk); #1;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        dm_ack   = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_dm_req", dm_req, 1'b0);
        check("rst_dm_addr", dm_addr, 32'h0);
        check("rst_dm_be", dm_be, 4'h0);
        check("rst_dm_wdata", dm_wdata, 32'h0);
        check("rst_flags", {misalign, bus_err, dm_we}, 3'b000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(3'd0, 32'h00000104, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_dm_addr", seen_addr, 32'h00000104);
        check("lw_dm_be", seen_be, 4'b1111);
        do_op(3'd3, 32'h00000301, 32'h0, 0, 32'h12F08034, 1'b0);
        check("lb_rdata", rdata, 32'hFFFFFF80);
        do_op(3'd4, 32'h00000301, 32'h0, 1, 32'h12F08034, 1'b0);
        check("lbu_rdata", rdata, 32'h00000080);
        do_op(3'd1, 32'h00000302, 32'h0, 2, 32'h12F08034, 1'b0);
        check("lh_rdata", rdata, 32'h000012F0);
        do_op(3'd7, 32'h00000203, 32'h000000A5, 0, 32'h0, 1'b0);
        check("sb_dm_be", seen_be, 4'b1000);
        check("sb_dm_wdata", seen_wd, 32'hA5A5A5A5);
        check("sb_dm_we", seen_we, 1'b1);
        check("sb_rdata_kept", rdata, 32'h000012F0);
        do_op(3'd6, 32'h00000202, 32'h00001234, 0, 32'h0, 1'b0);
        check("sh_dm_be", seen_be, 4'b1100);
        do_op(3'd0, 32'h00000102, 32'h0, 0, 32'h0, 1'b0);
        check("mis_lw_flag", seen_mis, 1'b1);
        check("mis_lw_noreq", seen_req, 1'b0);
        check("mis_lw_rdata", rdata, 32'h000012F0);
        do_op(3'd6, 32'h00000201, 32'h0, 0, 32'h0, 1'b0);
        check("mis_sh_flag", seen_mis, 1'b1);
        do_op(3'd0, 32'h00000400, 32'h0, 99, 32'h0, 1'b0);
        check("to_bus_err", seen_err, 1'b1);
        check("to_rdata_kept", rdata, 32'h000012F0);
        do_op(3'd0, 32'h00000400, 32'h0, TO - 1, 32'h55AA1234, 1'b1);
        check("to_ack_wins", seen_err, 1'b0);
        check("to_ack_rdata", rdata, 32'h55AA1234);

        // Reset in the middle of an access must abort it without a done pulse.
        start  = 1'b1;
        mem_op = 3'd0;
        addr   = 32'h00000400;
        wdata  = 32'h0;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_busy = 1'b1;
        exp_req  = 1'b1;
        exp_we   = 1'b0;
        exp_addr = 32'h00000400;
        exp_be   = 4'b1111;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_dm_req", dm_req, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_rdata", rdata, 32'h0);
        exp_busy  = 1'b0;
        exp_req   = 1'b0;
        exp_done  = 1'b0;
        exp_rdata = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(3'd2, 32'h00000012, 32'h0, 0, 32'h8001C0DE, 1'b0);
        check("post_rst_lhu", rdata, 32'h00008001);

        for (int k = 0; k < 200; k++) begin
            logic [2:0]  op;
            logic [31:0] a;
            op = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & 2'(4 - op_size(op));
            do_op(op, a, $urandom, $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
